// File: rtl/rails_pkg.sv
// Shared types and defaults for the PC redirect rail: fault causes, controller states, address width.
`default_nettype none

package rails_pkg;

  localparam int RAILS_ADDR_W = 8;

  typedef enum logic [1:0] {
    FAULT_NONE      = 2'd0,
    FAULT_OVERFLOW  = 2'd1,
    FAULT_UNDERFLOW = 2'd2,
    FAULT_CONFLICT  = 2'd3
  } fault_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } rs_state_e;

endpackage

`default_nettype wire

// File: rtl/return_stack_lifo_store.sv
// Return-address register array: one write port at the current level, combinational top-of-stack read.
`default_nettype none

module lifo_store #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              i_we,
  input  logic [LW-1:0]     i_level,
  input  logic [ADDR_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [LW-1:0]     w_rd_idx;

  assign w_rd_idx = i_level - LW'(1);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_level == LW'(i)) begin
          r_mem[i] <= i_wdata;
        end
      end
    end
  end

  // Decoded read so an empty stack (index wraps to all-ones) yields zero instead of an out-of-range access.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rd_idx == LW'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/return_stack.sv
// Call/return controller: zero-latency PC redirect for jump/call/return, LIFO of return addresses, fault FSM.
`default_nettype none

module return_stack
  import rails_pkg::*;
#(
  parameter int ADDR_W = RAILS_ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         async_rst_n,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            pc_in,
  input  logic                         jump_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         fault_clr,
  output logic [ADDR_W-1:0]            overwrite_data,
  output logic                         overwrite_en,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         fault,
  output logic [1:0]                   fault_cause
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);

  rs_state_e         r_state, w_state_n;
  fault_e            r_cause, w_cause_n;
  logic [LW-1:0]     r_level, w_level_n;
  logic              w_push;
  logic              w_full, w_empty;
  logic [1:0]        w_req_cnt;
  logic              w_conflict;
  logic              w_active;
  logic [ADDR_W-1:0] w_top;

  assign w_full     = (r_level == c_DEPTH);
  assign w_empty    = (r_level == '0);
  assign w_req_cnt  = {1'b0, jump_en} + {1'b0, call_en} + {1'b0, ret_en};
  assign w_conflict = (w_req_cnt > 2'd1);
  // Reset is folded in so the strobe drops the instant reset asserts, not at the next edge.
  assign w_active   = async_rst_n && clk_en && !flush && (r_state == ST_RUN);

  lifo_store #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LW     (LW)
  ) u_store (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .i_we        (w_push),
    .i_level     (r_level),
    .i_wdata     (pc_in + ADDR_W'(1)),
    .o_rdata     (w_top)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= ST_RUN;
      r_cause <= FAULT_NONE;
      r_level <= '0;
    end else begin
      r_state <= w_state_n;
      r_cause <= w_cause_n;
      r_level <= w_level_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cause_n = r_cause;
    w_level_n = r_level;
    w_push    = 1'b0;
    if (clk_en && flush) begin
      w_level_n = '0;
    end
    case (r_state)
      ST_RUN: begin
        if (clk_en && !flush) begin
          if (w_conflict) begin
            w_state_n = ST_FAULT;
            w_cause_n = FAULT_CONFLICT;
          end else if (call_en) begin
            if (w_full) begin
              w_state_n = ST_FAULT;
              w_cause_n = FAULT_OVERFLOW;
            end else begin
              w_push    = 1'b1;
              w_level_n = r_level + LW'(1);
            end
          end else if (ret_en) begin
            if (w_empty) begin
              w_state_n = ST_FAULT;
              w_cause_n = FAULT_UNDERFLOW;
            end else begin
              w_level_n = r_level - LW'(1);
            end
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_state_n = ST_RUN;
          w_cause_n = FAULT_NONE;
        end
      end
      default: begin
        w_state_n = ST_RUN;
        w_cause_n = FAULT_NONE;
      end
    endcase
  end

  always_comb begin
    overwrite_en   = 1'b0;
    overwrite_data = '0;
    if (w_active && !w_conflict) begin
      if (jump_en) begin
        overwrite_en   = 1'b1;
        overwrite_data = target;
      end else if (call_en && !w_full) begin
        overwrite_en   = 1'b1;
        overwrite_data = target;
      end else if (ret_en && !w_empty) begin
        overwrite_en   = 1'b1;
        overwrite_data = w_top;
      end
    end
  end

  assign level       = r_level;
  assign full        = w_full;
  assign empty       = w_empty;
  assign fault       = (r_state == ST_FAULT);
  assign fault_cause = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// Directed table-driven bench for return_stack plus hand sequences for overflow and async reset.
`default_nettype none

module tb_return_stack;
  import rails_pkg::*;

  logic       clk = 1'b0;
  logic       async_rst_n = 1'b0;
  logic       clk_en = 1'b0, flush = 1'b0, jump_en = 1'b0, call_en = 1'b0, ret_en = 1'b0, fault_clr = 1'b0;
  logic [7:0] pc_in = '0, target = '0;
  logic [7:0] overwrite_data;
  logic       overwrite_en, full, empty, fault;
  logic [3:0] level;
  logic [1:0] fault_cause;

  int total = 0;
  int bad   = 0;

  return_stack #(.ADDR_W(8), .DEPTH(8)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .flush(flush),
    .pc_in(pc_in), .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .fault_clr(fault_clr),
    .overwrite_data(overwrite_data), .overwrite_en(overwrite_en),
    .level(level), .full(full), .empty(empty), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en, fl, jp, cl, rt, fc;
    logic [7:0] pc, tg;
    logic       oe;
    logic [7:0] od;
    logic [3:0] lvl;
    logic       flt;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic en, fl, jp, cl, rt, fc, input logic [7:0] pc, tg,
                              input logic oe, input logic [7:0] od, input logic [3:0] lvl,
                              input logic flt, input logic [1:0] cause);
    vec_t v;
    v.en = en; v.fl = fl; v.jp = jp; v.cl = cl; v.rt = rt; v.fc = fc;
    v.pc = pc; v.tg = tg; v.oe = oe; v.od = od; v.lvl = lvl; v.flt = flt; v.cause = cause;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, fl, jp, cl, rt, fc, input logic [7:0] pc, tg);
    clk_en = en; flush = fl; jump_en = jp; call_en = cl; ret_en = rt; fault_clr = fc;
    pc_in = pc; target = tg;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.en, v.fl, v.jp, v.cl, v.rt, v.fc, v.pc, v.tg);
    #1;
    chk($sformatf("v%0d overwrite_en", idx), int'(overwrite_en), int'(v.oe));
    if (v.oe) chk($sformatf("v%0d overwrite_data", idx), int'(overwrite_data), int'(v.od));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d level", idx), int'(level), int'(v.lvl));
    chk($sformatf("v%0d fault", idx), int'(fault), int'(v.flt));
    chk($sformatf("v%0d fault_cause", idx), int'(fault_cause), int'(v.cause));
    chk($sformatf("v%0d empty", idx), int'(empty), int'(v.lvl == 4'd0));
    chk($sformatf("v%0d full", idx), int'(full), int'(v.lvl == 4'd8));
  endtask

  initial begin
    //            en fl jp cl rt fc  pc     tg    oe  od     lvl  flt cause
    vecs[0]  = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h40, 1, 8'h40, 4'd0, 0, 2'd0);
    vecs[1]  = mk(1, 0, 0, 1, 0, 0, 8'h10, 8'h80, 1, 8'h80, 4'd1, 0, 2'd0);
    vecs[2]  = mk(1, 0, 0, 1, 0, 0, 8'h20, 8'h90, 1, 8'h90, 4'd2, 0, 2'd0);
    vecs[3]  = mk(1, 0, 0, 1, 0, 0, 8'h30, 8'hA0, 1, 8'hA0, 4'd3, 0, 2'd0);
    vecs[4]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h31, 4'd2, 0, 2'd0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h21, 4'd1, 0, 2'd0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h11, 4'd0, 0, 2'd0);
    vecs[7]  = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 4'd0, 1, 2'd2);
    vecs[8]  = mk(1, 0, 1, 0, 0, 1, 8'h00, 8'h55, 0, 8'h00, 4'd0, 0, 2'd0);
    vecs[9]  = mk(1, 0, 0, 1, 1, 0, 8'h05, 8'h77, 0, 8'h00, 4'd0, 1, 2'd3);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 4'd0, 0, 2'd0);
    vecs[11] = mk(1, 0, 0, 1, 0, 0, 8'hFF, 8'hC0, 1, 8'hC0, 4'd1, 0, 2'd0);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 8'h12, 8'hD0, 0, 8'h00, 4'd1, 0, 2'd0);
    vecs[13] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h00, 4'd0, 0, 2'd0);
    vecs[14] = mk(1, 0, 0, 1, 0, 0, 8'h40, 8'h10, 1, 8'h10, 4'd1, 0, 2'd0);
    vecs[15] = mk(1, 1, 0, 1, 0, 0, 8'h50, 8'h20, 0, 8'h00, 4'd0, 0, 2'd0);
    vecs[16] = mk(1, 0, 0, 1, 0, 0, 8'h60, 8'h30, 1, 8'h30, 4'd1, 0, 2'd0);
    vecs[17] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h61, 4'd0, 0, 2'd0);
    vecs[18] = mk(1, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 4'd0, 1, 2'd2);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 4'd0, 0, 2'd0);

    // Reset state, checked while reset is still held and again after release.
    #2;
    chk("reset level", int'(level), 0);
    chk("reset empty", int'(empty), 1);
    chk("reset full", int'(full), 0);
    chk("reset fault", int'(fault), 0);
    chk("reset cause", int'(fault_cause), 0);
    chk("reset overwrite_en", int'(overwrite_en), 0);
    chk("reset overwrite_data", int'(overwrite_data), 0);
    @(negedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(i, vecs[i]);
    end

    // Overflow: fill all eight slots, then a ninth call faults.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 0, 0, 8'hE0 + 8'(i), 8'h00);
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("ovf level8", int'(level), 8);
    chk("ovf full", int'(full), 1);
    drive(1, 0, 0, 1, 0, 0, 8'h99, 8'h33);
    #1;
    chk("ovf overwrite_en", int'(overwrite_en), 0);
    @(posedge clk);
    #1;
    chk("ovf fault", int'(fault), 1);
    chk("ovf cause", int'(fault_cause), int'(FAULT_OVERFLOW));
    chk("ovf level held", int'(level), 8);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    #1;
    chk("ret in fault oe", int'(overwrite_en), 0);
    @(posedge clk);
    #1;
    chk("ret in fault level", int'(level), 8);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk("ovf cleared", int'(fault), 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    #1;
    chk("ovf ret oe", int'(overwrite_en), 1);
    chk("ovf ret data", int'(overwrite_data), 8'hE8);
    @(posedge clk);
    #1;
    chk("ovf ret level", int'(level), 7);

    // Async reset between edges with a call still requested.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 0, 0, 8'h70 + 8'(i), 8'h44);
      @(posedge clk);
    end
    #1;
    chk("pre-rst level", int'(level), 3);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 0, 8'h7F, 8'h44);
    #1;
    async_rst_n = 1'b0;
    #1;
    chk("arst level", int'(level), 0);
    chk("arst empty", int'(empty), 1);
    chk("arst overwrite_en", int'(overwrite_en), 0);
    @(posedge clk);
    #1;
    chk("arst push discarded", int'(level), 0);
    @(negedge clk);
    async_rst_n = 1'b1;
    drive(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    #1;
    chk("arst ret oe", int'(overwrite_en), 0);
    @(posedge clk);
    #1;
    chk("arst ret underflow", int'(fault_cause), int'(FAULT_UNDERFLOW));

    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/return_stack.md
# return_stack

Call/return controller that drives the program counter's overwrite path. It accepts jump, call and return requests from instruction decode, takes the current PC value as input, and keeps a LIFO of return addresses. It presents the redirect address and the overwrite strobe in the same cycle as the request, so the counter loads the target on the next enabled edge. It sits between decode and the program counter and is the only producer of `overwrite_data` / `overwrite_en`.

## Interface
- `ADDR_W`, 8: PC / address width.
- `DEPTH`, 8: return-address entries; legal values are 2 and above.

Ports:
- `clk`  in  1  single clock, rising edge.
- `async_rst_n`  in  1  asynchronous active-low reset.
- `clk_en`  in  1  advance enable, shared with the program counter; requests act only when it is high.
- `flush`  in  1  synchronous stack clear; acts only when `clk_en` is high.
- `pc_in`  in  ADDR_W  current PC, taken from the counter output.
- `jump_en`  in  1  unconditional jump request.
- `call_en`  in  1  call request: push `pc_in+1`, then redirect.
- `ret_en`  in  1  return request: pop, then redirect.
- `target`  in  ADDR_W  jump/call destination.
- `fault_clr`  in  1  clears the fault state.
- `overwrite_data`  out  ADDR_W  redirect address, to the PC.
- `overwrite_en`  out  1  redirect strobe, to the PC.
- `level`  out  $clog2(DEPTH+1)  current number of stacked entries.
- `full`  out  1  high when `level == DEPTH`.
- `empty`  out  1  high when `level == 0`.
- `fault`  out  1  high while in state FAULT.
- `fault_cause`  out  2  latched cause, encoded as a `fault_e` value.

## Operation
- States: RUN and FAULT.
- Reset enters RUN with `level=0`, `fault_cause=NONE`, and all storage zeroed.
- Outputs after reset: `overwrite_en=0`, `overwrite_data=0`, `empty=1`, `full=0`, `fault=0`.
- In RUN with `clk_en=1`, exactly one request (`jump_en`, `call_en`, `ret_en`) is legal per cycle:
  - **Jump:** `overwrite_data=target`, `overwrite_en=1`; the stack is unchanged.
  - **Call, not full:** `overwrite_data=target`, `overwrite_en=1`.
    - On the edge, `pc_in+1` (modulo 2^ADDR_W, so 0xFF+1 stores 0x00) is written at index `level`, and `level` increments.
  - **Return, not empty:** `overwrite_data=mem[level-1]` (top of stack, combinational), `overwrite_en=1`; `level` decrements on the edge.
- Faults, all entering FAULT on the edge with `overwrite_en=0` and no stack change:
  - Call while full: cause OVERFLOW.
  - Return while empty: cause UNDERFLOW.
  - Two or more requests in the same cycle: cause CONFLICT.
- `flush` with `clk_en=1`:
  - Sets `level=0` on the edge.
  - Takes priority over any request in that cycle; the request is ignored and `overwrite_en=0`.
  - Clears neither `fault` nor `fault_cause`.
- FAULT state:
  - All requests are ignored and `overwrite_en=0`.
  - Stack contents and `level` are preserved.
  - `fault_clr=1` returns to RUN on the next edge, regardless of `clk_en`, and sets `fault_cause=NONE`.
- With `clk_en=0`:
  - Requests and `flush` are ignored and `overwrite_en=0`; state does not change.
  - `fault_clr` still acts.
- `overwrite_en` is combinational from the requests, `clk_en`, the state and `level`. No registered output is allowed to lag the request.

## Timing
- Redirect latency is zero cycles: the strobe and data are valid in the request cycle, and the PC loads them on that cycle's rising edge.
- `level`, `full`, `empty`, `fault` and `fault_cause` are registered; they update on the edge that completes the operation.
- Back-to-back operations:
  - Call then return on consecutive enabled cycles returns `pc_in+1` from the call cycle.
  - Return then call reuses the freed slot.
- A return's read uses pre-edge `level`; there is no same-cycle read-after-write.
- Asynchronous reset asserted mid-operation:
  - Outputs go to their reset values immediately, with no edge needed.
  - Any push or pop in progress is discarded.
- `fault_clr` asserted in the same cycle as a fault-causing request while in RUN: the fault wins and the state stays FAULT.

## Structure
- The shared package `rails_pkg` holds:
  - `typedef enum logic [1:0] {FAULT_NONE, FAULT_OVERFLOW, FAULT_UNDERFLOW, FAULT_CONFLICT} fault_e`.
  - `typedef enum logic {ST_RUN, ST_FAULT} rs_state_e`.
  - `ADDR_W` default constant, shared with the program counter.
- Sub-module `lifo_store` contains the register-array storage:
  - One write port and one combinational read at `level-1`.
  - Asynchronous clear on reset.
- The FSM, pointer and overwrite mux stay in `return_stack`.

## Test plan
- **Reset and jump:** release reset, then `jump_en=1`, `target=0x40`, `clk_en=1` → `overwrite_en=1`, `overwrite_data=0x40` the same cycle; `level` stays 0.
- **Nested calls and returns:** calls at `pc_in` 0x10, 0x20, 0x30 (targets 0x80, 0x90, 0xA0), then three returns → return data 0x31, 0x21, 0x11; `level` goes 1,2,3,2,1,0 and `empty=1` at the end.
- **Overflow:** fill to DEPTH=8 (`full=1`), issue a 9th call → `overwrite_en=0`, `fault=1`, `fault_cause=OVERFLOW`, `level=8`.
  - A return while in FAULT is ignored.
  - Pulse `fault_clr`, then return → top-of-stack data and `level=7`.
- **Underflow and conflict:** return while empty → UNDERFLOW. After clearing, `call_en` and `ret_en` together → CONFLICT, with `overwrite_en=0` and `level` unchanged.
- **Wrap and enable gating:** call at `pc_in=0xFF` stores 0x00. `call_en` with `clk_en=0` → no push and no strobe. `flush` with a pending request → `level=0` and no strobe.
- **Async reset mid-stack:** `level=3`, assert `async_rst_n=0` between edges → `level=0`, `empty=1`, `overwrite_en=0` immediately.
